// File: rtl/hmmm_pkg.sv
// Shared definitions for the multi-cycle HMMM core: opcodes, FSM states,
// instruction field positions and the imm8 sign-extension helper.
package hmmm_pkg;

  typedef enum logic [3:0] {
    OP_HALT   = 4'h0,
    OP_SETN   = 4'h1,
    OP_LOADN  = 4'h2,
    OP_STOREN = 4'h3,
    OP_ADD    = 4'h4,
    OP_SUB    = 4'h5,
    OP_NEG    = 4'h6,
    OP_ADDN   = 4'h7,
    OP_JUMPN  = 4'h8,
    OP_JUMPR  = 4'h9,
    OP_JEQZN  = 4'hA,
    OP_JNEZN  = 4'hB,
    OP_JGTZN  = 4'hC,
    OP_JLTZN  = 4'hD,
    OP_CALLN  = 4'hE,
    OP_LOADR  = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RX_LO  = 8;
  localparam int RY_LO  = 4;
  localparam int RZ_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Result is masked to data_w bits; callers size-cast it to their width.
  function automatic logic [63:0] sext8(input logic [7:0] imm, input int data_w);
    logic [63:0] ext;
    logic [63:0] mask;
    ext  = {{56{imm[7]}}, imm};
    mask = (data_w >= 64) ? '1 : ((64'd1 << data_w) - 64'd1);
    return ext & mask;
  endfunction

endpackage

// File: rtl/hmmm_regfile.sv
// Register file for the HMMM core: two read ports, one write port, r0 reads
// as zero and ignores writes; synchronous clear on reset.
module hmmm_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 16,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic [RA_W-1:0]   ra_adr,
  input  logic [RA_W-1:0]   rb_adr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [RA_W-1:0]   w_adr,
  input  logic [DATA_W-1:0] w_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge ph1) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (w_adr != '0)) begin
      regs[w_adr] <= w_data;
    end
  end

  assign ra_data = (ra_adr == '0) ? '0 : regs[ra_adr];
  assign rb_data = (rb_adr == '0) ? '0 : regs[rb_adr];

endmodule

// File: rtl/hmmm_core_mc.sv
// Multi-cycle HMMM core: FETCH/EXEC/MEM/HALT FSM driving one unified
// instruction/data memory through a req/ready handshake.
module hmmm_core_mc
  import hmmm_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 16
) (
  input  logic              ph1,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam int RA_W = $clog2(NREGS);

  state_t            state, state_n;
  logic [15:0]       ir, ir_n;
  logic [ADDR_W-1:0] pc_q, pc_n, adr_q, adr_n, imm_addr, pc_inc;
  logic [DATA_W-1:0] wdata_q, wdata_n, imm_sext, load_val;
  logic [DATA_W-1:0] rd_a, rd_b, rf_wdata;
  logic              rf_we, is_store, a_neg, a_zero;
  opcode_t           op;
  logic [7:0]        imm;
  logic [RA_W-1:0]   rx, ry, rz, ra_sel;

  assign op       = opcode_t'(ir[OP_HI:OP_LO]);
  assign rx       = ir[RX_LO +: RA_W];
  assign ry       = ir[RY_LO +: RA_W];
  assign rz       = ir[RZ_LO +: RA_W];
  assign imm      = ir[IMM_HI:IMM_LO];
  assign imm_sext = DATA_W'(sext8(imm, DATA_W));
  assign load_val = DATA_W'(mem_rdata);
  assign pc_inc   = pc_q + ADDR_W'(1);
  assign is_store = (op == OP_STOREN);
  assign a_neg    = rd_a[DATA_W-1];
  assign a_zero   = (rd_a == '0);
  assign pc       = pc_q;

  always_comb begin
    imm_addr      = '0;
    imm_addr[7:0] = imm;
  end

  // Port A carries rY for the two-source and rY-based ops, otherwise rX.
  always_comb begin
    ra_sel = rx;
    if (op == OP_ADD || op == OP_SUB || op == OP_NEG || op == OP_LOADR) ra_sel = ry;
  end

  hmmm_regfile #(
    .DATA_W(DATA_W),
    .NREGS (NREGS)
  ) u_regfile (
    .ph1    (ph1),
    .reset  (reset),
    .ra_adr (ra_sel),
    .rb_adr (rz),
    .ra_data(rd_a),
    .rb_data(rd_b),
    .we     (rf_we),
    .w_adr  (rx),
    .w_data (rf_wdata)
  );

  always_ff @(posedge ph1) begin
    if (reset) begin
      state   <= S_FETCH;
      pc_q    <= '0;
      ir      <= '0;
      adr_q   <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      ir      <= ir_n;
      adr_q   <= adr_n;
      wdata_q <= wdata_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc_q;
    ir_n      = ir;
    adr_n     = adr_q;
    wdata_n   = wdata_q;
    rf_we     = 1'b0;
    rf_wdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    halted    = 1'b0;

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        mem_adr = pc_q;
        if (mem_ready) begin
          ir_n    = mem_rdata;
          state_n = S_EXEC;
        end
      end

      S_EXEC: begin
        state_n = S_FETCH;
        pc_n    = pc_inc;
        case (op)
          OP_HALT: begin
            state_n = S_HALT;
            pc_n    = pc_q;
          end
          OP_SETN: begin rf_we = 1'b1; rf_wdata = imm_sext; end
          OP_LOADN: begin
            adr_n   = imm_addr;
            state_n = S_MEM;
            pc_n    = pc_q;
          end
          OP_STOREN: begin
            adr_n   = imm_addr;
            wdata_n = rd_a;
            state_n = S_MEM;
            pc_n    = pc_q;
          end
          OP_ADD:   begin rf_we = 1'b1; rf_wdata = rd_a + rd_b; end
          OP_SUB:   begin rf_we = 1'b1; rf_wdata = rd_a - rd_b; end
          OP_NEG:   begin rf_we = 1'b1; rf_wdata = -rd_a; end
          OP_ADDN:  begin rf_we = 1'b1; rf_wdata = rd_a + imm_sext; end
          OP_JUMPN: pc_n = imm_addr;
          OP_JUMPR: pc_n = ADDR_W'(rd_a);
          OP_JEQZN: if (a_zero) pc_n = imm_addr;
          OP_JNEZN: if (!a_zero) pc_n = imm_addr;
          OP_JGTZN: if (!a_neg && !a_zero) pc_n = imm_addr;
          OP_JLTZN: if (a_neg) pc_n = imm_addr;
          OP_CALLN: begin
            rf_we    = 1'b1;
            rf_wdata = DATA_W'(pc_inc);
            pc_n     = imm_addr;
          end
          OP_LOADR: begin
            adr_n   = ADDR_W'(rd_a);
            state_n = S_MEM;
            pc_n    = pc_q;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        mem_req   = 1'b1;
        mem_adr   = adr_q;
        mem_we    = is_store;
        mem_wdata = is_store ? wdata_q : '0;
        if (mem_ready) begin
          pc_n    = pc_inc;
          state_n = S_FETCH;
          if (!is_store) begin
            rf_we    = 1'b1;
            rf_wdata = load_val;
          end
        end
      end

      S_HALT: halted = 1'b1;

      default: state_n = S_FETCH;
    endcase

    // Reset must silence the bus even mid-transfer.
    if (reset) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_adr   = '0;
      mem_wdata = '0;
      rf_we     = 1'b0;
      halted    = 1'b0;
    end
  end

endmodule

// File: tb/tb_hmmm_core_mc.sv
// Self-checking bench for hmmm_core_mc: an instruction-level reference model
// predicts every bus transfer, its timing, and the final memory contents.
module tb_hmmm_core_mc;

  logic        ph1 = 1'b0;
  logic        reset = 1'b1;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        mem_req, mem_we, halted;
  logic [7:0]  mem_adr, mem_wdata, pc;

  hmmm_core_mc #(.DATA_W(8), .ADDR_W(8), .NREGS(16)) dut (
    .ph1      (ph1),
    .reset    (reset),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_adr  (mem_adr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .pc       (pc),
    .halted   (halted)
  );

  always #5 ph1 = ~ph1;

  int errors = 0;
  int checks = 0;

  logic [15:0] devMem [256];
  logic [15:0] refMem [256];
  int refRegs [16];
  int refPc, expKind, expAdr, expWdata, memX, gap, waitLeft, hc;
  bit refHalted, found;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready);
    mem_ready = ready;
    mem_rdata = devMem[mem_adr];
  endtask

  function automatic int rd(input int i);
    return (i == 0) ? 0 : refRegs[i];
  endfunction

  function automatic void wr(input int i, input int v);
    if (i != 0) refRegs[i] = v & 255;
  endfunction

  function automatic int sgn(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic refInit();
    for (int i = 0; i < 16; i++) refRegs[i] = 0;
    refPc = 0; refHalted = 0; expKind = 0; expAdr = 0; gap = 0;
  endtask

  task automatic put(input int adr, input logic [15:0] word);
    devMem[adr] = word;
    refMem[adr] = word;
  endtask

  task automatic clearMem(input logic [15:0] fill);
    for (int i = 0; i < 256; i++) put(i, fill);
  endtask

  // Instruction-level semantics; expKind 0 = fetch next, 1 = load, 2 = store.
  task automatic issExec(input logic [15:0] instr);
    int op, x, y, z, imm, simm, nxt;
    op = instr[15:12]; x = instr[11:8]; y = instr[7:4]; z = instr[3:0];
    imm = instr[7:0]; simm = sgn(imm); nxt = (refPc + 1) % 256;
    expKind = 0;
    case (op)
      0:  refHalted = 1;
      1:  begin wr(x, simm); refPc = nxt; end
      2:  begin expKind = 1; expAdr = imm; memX = x; end
      3:  begin expKind = 2; expAdr = imm; expWdata = rd(x); end
      4:  begin wr(x, rd(y) + rd(z)); refPc = nxt; end
      5:  begin wr(x, rd(y) - rd(z)); refPc = nxt; end
      6:  begin wr(x, 0 - rd(y)); refPc = nxt; end
      7:  begin wr(x, rd(x) + simm); refPc = nxt; end
      8:  refPc = imm;
      9:  refPc = rd(x);
      10: refPc = (rd(x) == 0) ? imm : nxt;
      11: refPc = (rd(x) != 0) ? imm : nxt;
      12: refPc = (sgn(rd(x)) > 0) ? imm : nxt;
      13: refPc = (sgn(rd(x)) < 0) ? imm : nxt;
      14: begin wr(x, nxt); refPc = imm; end
      default: begin expKind = 1; expAdr = rd(y); memX = x; end
    endcase
    if (expKind == 0) expAdr = refPc;
  endtask

  task automatic issMemDone();
    if (expKind == 1) wr(memX, int'(refMem[expAdr][7:0]));
    else refMem[expAdr] = 16'(expWdata);
    refPc = (refPc + 1) % 256;
    expKind = 0;
    expAdr = refPc;
  endtask

  task automatic applyReset();
    @(negedge ph1);
    reset = 1'b1;
    mem_ready = 1'b0;
    #1 checkOutput("reqInReset", mem_req, 0);
    @(negedge ph1);
    checkOutput("pcAfterReset", pc, 0);
    checkOutput("haltedAfterReset", halted, 0);
    reset = 1'b0;
    refInit();
  endtask

  // Called at a negedge; runs until halted (plus a few cycles) or maxCycles.
  task automatic runCore(input int maxCycles, input int waitLo, input int waitHi, output int haltCycle);
    int haltStay;
    bit active, done, sWe;
    logic [7:0] sAdr, sWdata;
    haltCycle = -1;
    haltStay = 0;
    waitLeft = $urandom_range(waitHi, waitLo);
    for (int cyc = 0; cyc < maxCycles; cyc++) begin
      #1;
      active = (gap == 0) && !refHalted;
      if (gap > 0) begin
        checkOutput("execReq", mem_req, 0);
        checkOutput("execWe", mem_we, 0);
        checkOutput("execWdata", mem_wdata, 0);
        gap--;
      end else if (refHalted) begin
        checkOutput("haltFlag", halted, 1);
        checkOutput("haltReq", mem_req, 0);
        if (haltCycle < 0) haltCycle = cyc;
        haltStay++;
        if (haltStay > 2) break;
      end else begin
        checkOutput("req", mem_req, 1);
        checkOutput("adr", mem_adr, expAdr);
        checkOutput("we", mem_we, expKind == 2);
        checkOutput("wdata", mem_wdata, (expKind == 2) ? expWdata : 0);
        checkOutput("notHalted", halted, 0);
        if (expKind == 0) checkOutput("pc", pc, expAdr);
      end
      applyStimulus(active ? (waitLeft == 0) : 1'($urandom_range(1, 0)));
      done = mem_req && mem_ready;
      sAdr = mem_adr; sWe = mem_we; sWdata = mem_wdata;
      @(posedge ph1);
      if (done && sWe) devMem[sAdr] = {8'h00, sWdata};
      if (active) begin
        if (done) begin
          if (expKind == 0) begin
            gap = 1;
            issExec(refMem[refPc]);
          end else begin
            issMemDone();
          end
          waitLeft = $urandom_range(waitHi, waitLo);
        end else if (waitLeft > 0) begin
          waitLeft--;
        end
      end
      @(negedge ph1);
    end
  endtask

  initial begin
    refInit();
    clearMem(16'h0000);

    // setn/setn/add/halt: halted visible after the eighth edge.
    applyReset();
    clearMem(16'h0000);
    put(0, 16'h1105); put(1, 16'h12FD); put(2, 16'h4312); put(3, 16'h0000);
    runCore(60, 0, 0, hc);
    checkOutput("t1HaltEdge", hc, 8);

    applyReset();
    clearMem(16'h0000);
    put(0, 16'h1105); put(1, 16'h12FD); put(2, 16'h4312); put(3, 16'h3390);
    runCore(60, 0, 0, hc);
    checkOutput("t1SumR3", devMem[8'h90], 16'h0002);

    // Store then load through a slow memory.
    applyReset();
    clearMem(16'h0000);
    put(0, 16'h115A); put(1, 16'h3180); put(2, 16'h2480); put(3, 16'h3481);
    runCore(200, 3, 3, hc);
    checkOutput("t2Store", devMem[8'h80], 16'h005A);
    checkOutput("t2LoadBack", devMem[8'h81], 16'h005A);

    // Conditional branches, signed test of rX.
    applyReset();
    clearMem(16'h0000);
    put(8'h00, 16'h1180); put(8'h01, 16'hD120);
    put(8'h20, 16'h1101); put(8'h21, 16'hA130); put(8'h22, 16'hC040);
    runCore(80, 0, 1, hc);
    checkOutput("t3Halted", hc >= 0, 1);
    checkOutput("t3FinalPc", pc, 8'h23);

    // r0 discard, calln link value, jumpr return.
    applyReset();
    clearMem(16'h0000);
    put(8'h00, 16'h1007); put(8'h01, 16'h4200); put(8'h02, 16'h3290); put(8'h03, 16'h8010);
    put(8'h10, 16'hE540); put(8'h40, 16'h3591); put(8'h41, 16'h9500);
    put(8'h90, 16'hFFFF); put(8'h91, 16'hFFFF);
    runCore(120, 0, 2, hc);
    checkOutput("t4R2Zero", devMem[8'h90], 16'h0000);
    checkOutput("t4Link", devMem[8'h91], 16'h0011);
    checkOutput("t4FinalPc", pc, 8'h11);

    // pc wraps from 0xFF to 0x00; addn wraps 0xFF + 1 to 0.
    applyReset();
    clearMem(16'h0000);
    put(8'h00, 16'hA2F0); put(8'h01, 16'h3192);
    put(8'hF0, 16'h1201); put(8'hF1, 16'h11FF); put(8'hF2, 16'h80FF); put(8'hFF, 16'h7101);
    put(8'h92, 16'hFFFF);
    runCore(120, 0, 1, hc);
    checkOutput("t5AddnWrap", devMem[8'h92], 16'h0000);
    checkOutput("t5FinalPc", pc, 8'h02);

    // Reset while a store is stalled in MEM.
    applyReset();
    clearMem(16'h0000);
    put(0, 16'h1177); put(1, 16'h3180);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (mem_req && mem_we) begin
        found = 1;
        mem_ready = 1'b0;
      end else begin
        applyStimulus(1'b1);
        @(negedge ph1);
      end
    end
    checkOutput("t6ReachMem", found, 1);
    checkOutput("t6MemAdr", mem_adr, 8'h80);
    checkOutput("t6MemData", mem_wdata, 8'h77);
    @(negedge ph1);
    #1 checkOutput("t6HeldReq", mem_req, 1);
    checkOutput("t6HeldAdr", mem_adr, 8'h80);
    reset = 1'b1;
    #1 checkOutput("t6ReqDuringReset", mem_req, 0);
    checkOutput("t6WeDuringReset", mem_we, 0);
    clearMem(16'h0000);
    put(0, 16'h3183); put(8'h83, 16'hFFFF);
    @(negedge ph1);
    reset = 1'b0;
    refInit();
    #1 checkOutput("t6PcZero", pc, 0);
    checkOutput("t6FetchReq", mem_req, 1);
    checkOutput("t6FetchAdr", mem_adr, 0);
    checkOutput("t6FetchWe", mem_we, 0);
    runCore(60, 0, 1, hc);
    checkOutput("t6RegsCleared", devMem[8'h83], 16'h0000);

    // Random programs against the reference model.
    for (int run = 0; run < 8; run++) begin
      applyReset();
      for (int i = 0; i < 256; i++) begin
        int op;
        op = ($urandom_range(39, 0) == 0) ? 0 : $urandom_range(15, 1);
        put(i, {4'(op), 12'($urandom)});
      end
      runCore(300, 0, (run % 2 == 0) ? 0 : 3, hc);
      for (int i = 0; i < 256; i++) checkOutput("randMem", devMem[i], refMem[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
